// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 codes for loads and stores
//   - mem_sign_mask access descriptors, laid out as {sign, mask[2:0]}
//   - FSM state encodings
//   - default memory-map parameters (data memory window, LED register)
package load_store_unit_pkg;

  // Memory-map defaults
  localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] DMEM_SIZE_DEF = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR_DEF  = 32'h0000_2000;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // mem_sign_mask encodings: bit 3 requests sign extension, bits 2:0 are the
  // byte-enable style width mask (byte = 001, half = 011, word = 111).
  localparam logic [3:0] SM_LB  = 4'b1001;
  localparam logic [3:0] SM_LBU = 4'b0001;
  localparam logic [3:0] SM_LH  = 4'b1011;
  localparam logic [3:0] SM_LHU = 4'b0011;
  localparam logic [3:0] SM_LW  = 4'b0111;
  localparam logic [3:0] SM_SB  = 4'b0001;
  localparam logic [3:0] SM_SH  = 4'b0011;
  localparam logic [3:0] SM_SW  = 4'b0111;

  // FSM states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decoder for the load/store unit.
// Inputs : write (1 = store), funct3, addr, wdata (right-aligned store data)
// Outputs: sign_mask (access descriptor), lane_data (store data moved to its
//          byte lane), err (illegal funct3, misaligned, or unmapped address)
module lsu_decode
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF
) (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  sign_mask,
  output logic [31:0] lane_data,
  output logic        err
);

  // 33-bit window bounds so a window ending at 2^32 does not wrap.
  localparam logic [32:0] WIN_LO = {1'b0, DMEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

  logic f3_ok;
  logic misaligned;
  logic in_dmem;
  logic is_led;

  always_comb begin
    sign_mask = 4'b0000;
    f3_ok     = 1'b0;
    unique case (funct3)
      F3_LB:   begin sign_mask = write ? SM_SB : SM_LB; f3_ok = 1'b1; end
      F3_LH:   begin sign_mask = write ? SM_SH : SM_LH; f3_ok = 1'b1; end
      F3_LW:   begin sign_mask = write ? SM_SW : SM_LW; f3_ok = 1'b1; end
      // Unsigned loads have no store counterpart.
      F3_LBU:  begin sign_mask = SM_LBU; f3_ok = !write; end
      F3_LHU:  begin sign_mask = SM_LHU; f3_ok = !write; end
      default: begin sign_mask = 4'b0000; f3_ok = 1'b0; end
    endcase
  end

  // funct3[1:0] gives the access size for every legal code.
  always_comb begin
    unique case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign in_dmem   = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  // The LED register only accepts full-word stores.
  assign is_led    = write && (funct3 == F3_SW) && (addr == LED_ADDR);
  assign err       = !f3_ok || misaligned || !(in_dmem || is_led);
  assign lane_data = wdata << {addr[1:0], 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store at a time from the pipeline,
// issues it to data memory as a one-cycle strobe and returns a response.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_write, req_funct3,
//   req_addr, req_wdata            request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_err              load result (0 for stores/errors), error
//   mem_addr, mem_write_data,
//   mem_memwrite, mem_memread,
//   mem_sign_mask                  data memory command
//   mem_read_data                  extended load data from memory
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_sign_mask_q, mem_sign_mask_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [3:0]  dec_sign_mask;
  logic [31:0] dec_lane_data;
  logic        dec_err;
  logic        accept;

  lsu_decode #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE),
    .LED_ADDR  (LED_ADDR)
  ) u_decode (
    .write     (req_write),
    .funct3    (req_funct3),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .sign_mask (dec_sign_mask),
    .lane_data (dec_lane_data),
    .err       (dec_err)
  );

  // Gated with rst_n so ready reads 0 for the whole reset window, not just
  // after the next clock edge.
  assign req_ready = rst_n && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_sign_mask_d = mem_sign_mask_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d    = req_write;
          rsp_data_d = 32'h0;
          rsp_err_d  = dec_err;
          if (dec_err) begin
            // Errored requests never reach memory; memory command regs keep
            // their old contents, which is harmless since no strobe follows.
            state_d = S_RESP;
          end else begin
            state_d         = S_ISSUE;
            mem_addr_d      = req_addr;
            mem_wdata_d     = dec_lane_data;
            mem_sign_mask_d = dec_sign_mask;
          end
        end
      end
      S_ISSUE:   state_d = write_q ? S_RESP : S_RD_WAIT;
      S_RD_WAIT: begin
        rsp_data_d = mem_read_data;
        state_d    = S_RESP;
      end
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      write_q         <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      mem_sign_mask_q <= 4'h0;
      rsp_data_q      <= 32'h0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_sign_mask_q <= mem_sign_mask_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  // Strobes decode straight from state so they drop the instant reset
  // forces the state back to IDLE.
  assign mem_memread    = (state_q == S_ISSUE) && !write_q;
  assign mem_memwrite   = (state_q == S_ISSUE) &&  write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_sign_mask  = mem_sign_mask_q;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;

endmodule
